// File: rtl/controller_multi_timer.sv
// Multi-channel down-counting timer with a small register-mapped slave port.
// Each channel has STATUS, CONTROL, PERIOD and SNAPSHOT registers and its own interrupt.
module controller_multi_timer #(
  parameter int          N_CH           = 4,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0002_49EF,
  parameter int          ADDR_W         = 2 + $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [N_CH-1:0]   irq,
  output logic              irq_any
);

  localparam logic [CNT_W-1:0] DEF_P = DEFAULT_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q    [N_CH];
  logic [CNT_W-1:0] period_q [N_CH];
  logic [CNT_W-1:0] snap_q   [N_CH];
  logic [N_CH-1:0]  run_q;
  logic [N_CH-1:0]  to_q;
  logic [N_CH-1:0]  cont_q;
  logic [N_CH-1:0]  ito_q;

  // Bus: a write is accepted in any cycle with chipselect=1 and write_n=0; there is no
  // wait state. readdata is sampled from address every cycle and is valid one cycle later.
  logic        wr;
  logic [31:0] ch_sel;
  logic [1:0]  reg_sel;
  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] expire;
  logic [31:0] rd_next;

  assign wr      = chipselect & ~write_n;
  assign ch_sel  = 32'(address >> 2);
  assign reg_sel = address[1:0];

  always_comb begin
    wr_hit  = '0;
    expire  = '0;
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr && (ch_sel == 32'(i));
      expire[i] = run_q[i] && (cnt_q[i] == '0);
      if (ch_sel == 32'(i)) begin
        case (reg_sel)
          2'd0:    rd_next = {30'b0, run_q[i], to_q[i]};
          2'd1:    rd_next = {30'b0, cont_q[i], ito_q[i]};
          2'd2:    rd_next = 32'(period_q[i]);
          default: rd_next = 32'(snap_q[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      run_q    <= '0;
      to_q     <= '0;
      cont_q   <= '0;
      ito_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]    <= DEF_P;
        period_q[i] <= DEF_P;
        snap_q[i]   <= '0;
      end
    end else begin
      readdata <= rd_next;
      for (int i = 0; i < N_CH; i++) begin
        if (run_q[i]) begin
          if (expire[i]) begin
            cnt_q[i] <= period_q[i];
            to_q[i]  <= 1'b1;
            if (!cont_q[i]) run_q[i] <= 1'b0;
          end else begin
            cnt_q[i] <= cnt_q[i] - 1'b1;
          end
        end
        // Bus writes come after the count step so they override it (later NBA wins).
        if (wr_hit[i]) begin
          case (reg_sel)
            2'd0: if (!expire[i]) to_q[i] <= 1'b0;
            2'd1: begin
              cont_q[i] <= writedata[1];
              ito_q[i]  <= writedata[0];
              if (writedata[2])      run_q[i] <= 1'b1;
              else if (writedata[3]) run_q[i] <= 1'b0;
            end
            2'd2: begin
              period_q[i] <= writedata[CNT_W-1:0];
              cnt_q[i]    <= writedata[CNT_W-1:0];
              run_q[i]    <= 1'b0;
            end
            default: snap_q[i] <= cnt_q[i];
          endcase
        end
      end
    end
  end

  assign irq     = to_q & ito_q;
  assign irq_any = |irq;

endmodule

// File: tb/tb_controller_multi_timer.sv
// Bench for controller_multi_timer: directed scenarios plus random bus traffic,
// checked every cycle against a cycles-to-timeout reference model.
module tb_controller_multi_timer;

  localparam logic [31:0] DEF_P = 32'h0002_49EF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  irq;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  controller_multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_any    (irq_any)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: m_left is the number of running cycles until the next timeout.
  longint      m_left [4];
  logic [31:0] m_per  [4];
  logic [31:0] m_snap [4];
  bit          m_run [4], m_to [4], m_cont [4], m_ito [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_per[c]  = DEF_P;
      m_left[c] = longint'(DEF_P) + 1;
      m_snap[c] = '0;
      m_run[c]  = 0; m_to[c] = 0; m_cont[c] = 0; m_ito[c] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int c = int'(a[3:2]);
    case (a[1:0])
      2'd0:    return {30'b0, m_run[c], m_to[c]};
      2'd1:    return {30'b0, m_cont[c], m_ito[c]};
      2'd2:    return m_per[c];
      default: return m_snap[c];
    endcase
  endfunction

  function automatic logic [3:0] model_irq();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_to[c] & m_ito[c];
    return v;
  endfunction

  task automatic model_step(input logic cs, input logic wn, input logic [3:0] a,
                            input logic [31:0] wd);
    bit     fired [4];
    longint live  [4];
    int     c;
    for (int k = 0; k < 4; k++) begin
      live[k]  = m_left[k] - 1;
      fired[k] = 0;
      if (m_run[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          fired[k]  = 1;
          m_to[k]   = 1;
          m_left[k] = longint'(m_per[k]) + 1;
          if (!m_cont[k]) m_run[k] = 0;
        end
      end
    end
    if (cs && !wn) begin
      c = int'(a[3:2]);
      case (a[1:0])
        2'd0: if (!fired[c]) m_to[c] = 0;
        2'd1: begin
          m_cont[c] = wd[1];
          m_ito[c]  = wd[0];
          if (wd[2])      m_run[c] = 1;
          else if (wd[3]) m_run[c] = 0;
        end
        2'd2: begin
          m_per[c]  = wd;
          m_left[c] = longint'(wd) + 1;
          m_run[c]  = 0;
        end
        default: m_snap[c] = 32'(live[c]);
      endcase
    end
  endtask

  // driver: one bus cycle, model advanced at the edge, outputs checked #1 later
  task automatic bus_cycle(input logic cs, input logic wn, input logic [3:0] a,
                           input logic [31:0] wd);
    logic [3:0] ei;
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    exp_q.push_back(model_read(a));
    @(posedge clk);
    model_step(cs, wn, a, wd);
    #1;
    ei = model_irq();
    check("readdata", readdata, exp_q.pop_front());
    check("irq", 32'(irq), 32'(ei));
    check("irq_any", 32'(irq_any), 32'(|ei));
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] wd);
    bus_cycle(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    bus_cycle(1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus_cycle(1'b0, 1'b1, 4'h0, 32'h0);
  endtask

  initial begin
    logic [3:0]  ra;
    logic [31:0] rw;
    model_reset();
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_irq_any", 32'(irq_any), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    rd_reg(4'd2);
    check("reset_period", readdata, DEF_P);

    // ch0 continuous, period 4: irq on the 5th cycle after RUN
    wr_reg(4'd2, 32'd4);
    wr_reg(4'd1, 32'h7);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      check("ch0_irq_timing", 32'(irq[0]), (k >= 5) ? 32'd1 : 32'd0);
    end
    wr_reg(4'd1, 32'h8);

    // ch1 one-shot, period 3
    wr_reg(4'd6, 32'd3);
    wr_reg(4'd5, 32'h5);
    idle(3);
    check("ch1_not_yet", 32'(irq[1]), 32'd0);
    idle(1);
    check("ch1_irq", 32'(irq[1]), 32'd1);
    rd_reg(4'd4);
    check("ch1_status", readdata, 32'h1);
    wr_reg(4'd7, 32'h0);
    rd_reg(4'd7);
    check("ch1_reloaded", readdata, 32'd3);

    // ch2 continuous, period 0: STATUS clear loses to coincident timeout
    wr_reg(4'd10, 32'd0);
    wr_reg(4'd9, 32'h6);
    idle(2);
    wr_reg(4'd8, 32'h0);
    rd_reg(4'd8);
    check("ch2_to_kept", readdata, 32'h3);
    rd_reg(4'd9);
    check("ch2_control", readdata, 32'h2);

    // ch3 snapshot at counter 0x10
    wr_reg(4'd14, 32'h20);
    wr_reg(4'd13, 32'h4);
    idle(16);
    wr_reg(4'd15, 32'h0);
    idle(3);
    rd_reg(4'd15);
    check("ch3_snapshot", readdata, 32'h10);

    // PERIOD write while running stops the channel; START beats STOP
    wr_reg(4'd14, 32'h40);
    rd_reg(4'd12);
    check("ch3_stopped", readdata & 32'h2, 32'h0);
    wr_reg(4'd15, 32'h0);
    rd_reg(4'd15);
    check("ch3_loaded", readdata, 32'h40);
    wr_reg(4'd13, 32'hC);
    rd_reg(4'd12);
    check("ch3_start_wins", readdata & 32'h2, 32'h2);
    rd_reg(4'd13);
    check("ch3_control", readdata, 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ra = 4'($urandom_range(0, 15));
      case (ra[1:0])
        2'd1:    rw = $urandom_range(0, 15);
        2'd2:    rw = $urandom_range(0, 12);
        default: rw = $urandom;
      endcase
      bus_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
    end

    // reset mid-count with TO set
    wr_reg(4'd10, 32'd0);
    wr_reg(4'd9, 32'h7);
    idle(3);
    check("pre_reset_irq2", 32'(irq[2]), 32'd1);
    chipselect = 1'b0; write_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_irq_any", 32'(irq_any), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);
    rd_reg(4'd10);
    check("post_reset_period", readdata, DEF_P);
    rd_reg(4'd8);
    check("post_reset_status", readdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controller_multi_timer.md
CONTROLLER_MULTI_TIMER -- requirements
Module: controller_multi_timer

Interface
REQ-001 Parameter N_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter and period width in bits (2..32).
REQ-003 Parameter DEFAULT_PERIOD, default 32'h0002_49EF, reset value of every channel period and counter (truncated to CNT_W).
REQ-004 Parameter ADDR_W, default 2+clog2(N_CH), address width.
REQ-005 clk input 1, clock.
REQ-006 reset_n input 1, reset, asynchronous, active-low.
REQ-007 chipselect input 1, slave select.
REQ-008 write_n input 1, active-low write strobe.
REQ-009 address input ADDR_W, {channel, reg[1:0]}.
REQ-010 writedata input 32, write data.
REQ-011 readdata output 32, registered read data.
REQ-012 irq output N_CH, per-channel interrupt.
REQ-013 irq_any output 1, OR of irq.

Function
REQ-014 Registers per channel: reg 0 STATUS {RUN[1], TO[0]}; reg 1 CONTROL {STOP[3], START[2], CONT[1], ITO[0]}; reg 2 PERIOD; reg 3 SNAPSHOT.
REQ-015 Write = chipselect & ~write_n; channel index >= N_CH: writes ignored, reads return 0.
REQ-016 Read latency one cycle: readdata registered every cycle from address; unused bits 0; CONTROL reads return {2'b00, CONT, ITO}.
REQ-017 STATUS write (any data) clears TO.
REQ-018 CONTROL write stores CONT, ITO; START=1 sets RUN next cycle; STOP=1 clears RUN next cycle; START and STOP both 1 -> START wins.
REQ-019 PERIOD write stores writedata[CNT_W-1:0], loads counter with new period next cycle, clears RUN (same-cycle START ignored).
REQ-020 SNAPSHOT write copies live counter into snapshot register; SNAPSHOT read returns held value, not live counter.
REQ-021 While RUN=1: counter != 0 -> decrement by 1; counter == 0 -> reload PERIOD, set TO; CONT=0 also clears RUN.
REQ-022 Timeout interval = PERIOD+1 cycles; PERIOD=0 with CONT=1 sets TO every cycle.
REQ-023 While RUN=0 counter holds value; restart resumes from held value.
REQ-024 Same-cycle TO set and STATUS clear -> TO ends 1 (set wins).
REQ-025 irq[i] = TO[i] & ITO[i], combinational from registers; clearing ITO deasserts irq without clearing TO.
REQ-026 Channels fully independent; no shared prescaler or cross-channel state.
REQ-027 Counter arithmetic modulo 2^CNT_W; no underflow past 0.

Reset
REQ-028 reset_n low asynchronously sets: counter, PERIOD = DEFAULT_PERIOD; snapshot 0; RUN, TO, CONT, ITO 0; readdata 0; irq 0; irq_any 0.
REQ-029 Reset mid-count discards in-progress count; no TO/irq generated on reset release.

Verification
REQ-030 Ch0 PERIOD=4, CONTROL=0x7 -> TO set and irq[0], irq_any high 5 cycles after RUN=1; repeats every 5 cycles.
REQ-031 Ch1 PERIOD=3, CONTROL=0x5 (one-shot) -> single TO after 4 cycles, RUN reads 0, counter reloaded to 3.
REQ-032 Ch2 running continuous, PERIOD=0 -> TO set each cycle; STATUS write coincident with timeout leaves TO=1.
REQ-033 Ch3 running, SNAPSHOT write at counter=0x10 -> later SNAPSHOT read returns 0x10 one cycle after read address.
REQ-034 PERIOD write while running -> RUN=0, counter = new period; CONTROL=0xC -> RUN=1 (START wins).
REQ-035 Assert reset_n low mid-count with TO=1 -> all outputs 0 immediately, PERIOD reads DEFAULT_PERIOD after release.
